exe_alu_iter: RTL

Parametrised integer execute unit that succeeds the single-cycle I-type executor. It handles OP-IMM (`INST_TYPE_I`) and, optionally, OP (R-type) instructions at XLEN width. Shifts run on an iterative serial shifter so they cost no wide barrel shifter. The unit sits between the ID/EX operand stage and the writeback stage and talks to both over valid/ready handshakes.

---
 rtl/exe_alu_iter_pkg.sv | 38 +++
 rtl/exe_alu_iter_shift.sv | 91 +++++++++
 rtl/exe_alu_iter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/exe_alu_iter_pkg.sv
// ----------------------------------------------------------------------------
// exe_alu_iter_pkg
// Shared constants for the iterative integer execute unit: opcodes, funct3 /
// funct7 encodings, write-enable levels, FSM state encodings and the serial
// shifter operation kind.
// ----------------------------------------------------------------------------
package exe_alu_iter_pkg;

    localparam logic [6:0] INST_TYPE_I = 7'b0010011;   // OP-IMM
    localparam logic [6:0] INST_TYPE_R = 7'b0110011;   // OP

    localparam logic [2:0] F3_ADD  = 3'b000;           // ADD/ADDI/SUB
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;           // SRL/SRA and immediates
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;       // SUB / SRA

    localparam logic [63:0] ZERO          = 64'd0;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_kind_e;

endpackage

// File: rtl/exe_alu_iter_shift.sv
// ----------------------------------------------------------------------------
// exe_shift_serial
// Iterative shifter: shifts a latched operand by up to SHIFT_STEP bits per
// clock until the requested amount is used up.
//   clk_i, rst_i : clock, async active-high reset
//   start_i      : load data_i/amt_i/kind_i (amt_i must be non-zero)
//   kind_i       : SLL / SRL / SRA
//   busy_o       : a shift is in progress
//   done_o       : the coming edge performs the final step
//   data_o       : shift register contents (final result once done)
//   next_o       : shift register value after the coming edge
// ----------------------------------------------------------------------------
module exe_shift_serial
    import exe_alu_iter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHAMT_W    = $clog2(XLEN),
    parameter int SHIFT_STEP = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  shift_kind_e        kind_i,
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] amt_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [XLEN-1:0]    data_o,
    output logic [XLEN-1:0]    next_o
);

    // One extra bit so SHIFT_STEP == XLEN is representable.
    localparam int              CNT_W  = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(SHIFT_STEP);

    logic [XLEN-1:0]  r_data;
    logic [CNT_W-1:0] r_cnt;
    shift_kind_e      r_kind;
    logic             r_sign;
    logic             r_busy;

    logic [CNT_W-1:0] w_step;
    logic [XLEN-1:0]  w_next;
    logic [XLEN-1:0]  w_fill;

    assign w_step = (r_cnt < STEP_C) ? r_cnt : STEP_C;
    assign w_fill = {XLEN{r_sign}};

    // Only shift distances 1..SHIFT_STEP are ever needed, so build a small
    // mux over constant shifts instead of a full barrel shifter.
    always_comb begin
        w_next = r_data;
        for (int k = 1; k <= SHIFT_STEP; k++) begin
            if (w_step == CNT_W'(k)) begin
                case (r_kind)
                    SH_SLL:  w_next = r_data << k;
                    SH_SRL:  w_next = r_data >> k;
                    default: w_next = (r_data >> k) | (w_fill << (XLEN - k));
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_kind <= SH_SLL;
            r_sign <= 1'b0;
            r_busy <= 1'b0;
        end else if (start_i) begin
            r_data <= data_i;
            r_cnt  <= {1'b0, amt_i};
            r_kind <= kind_i;
            r_sign <= data_i[XLEN-1];
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_data <= w_next;
            r_cnt  <= r_cnt - w_step;
            if (r_cnt <= STEP_C) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_busy && (r_cnt <= STEP_C);
    assign data_o = r_data;
    assign next_o = w_next;

endmodule

// File: rtl/exe_alu_iter.sv
// ----------------------------------------------------------------------------
// exe_alu_iter
// Integer execute unit for OP-IMM and (optionally) OP instructions. Non-shift
// operations complete in the accept cycle; non-zero shifts run on the serial
// shifter. Valid/ready handshakes on both the operand and result sides.
//   clk_i, rst_i             : clock, async active-high reset
//   in_valid_i / in_ready_o  : operand-side handshake
//   op1_i, op2_i, inst_i     : rs1, imm-or-rs2, raw instruction
//   out_valid_o / out_ready_i: result-side handshake
//   reg_wdata_o, reg_we_o    : result and write enable (0 for illegal)
//   rd_o                     : destination register of the result
//   busy_o                   : FSM not in IDLE
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | ready for a new instruction
// ST_SHIFT | serial shift in progress
// ST_HOLD  | shift finished, waiting for the result register
// ----------------------------------------------------------------------------
module exe_alu_iter
    import exe_alu_iter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHAMT_W    = $clog2(XLEN),
    parameter int SHIFT_STEP = 1,
    parameter int ENABLE_R   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [31:0]     inst_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] reg_wdata_o,
    output logic            reg_we_o,
    output logic [4:0]      rd_o,
    output logic            busy_o
);

    // Upper immediate bits above the shift amount; SRAI marks them 010..0.
    localparam int                 UPPER_W    = 12 - SHAMT_W;
    localparam logic [UPPER_W-1:0] SRAI_UPPER = UPPER_W'(1) << (UPPER_W - 2);

    logic [1:0]      r_state;
    logic            r_valid;
    logic [XLEN-1:0] r_wdata;
    logic            r_we;
    logic [4:0]      r_rd;
    logic [4:0]      r_rd_pend;

    logic [6:0]         w_opcode;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic [4:0]         w_rd;
    logic [UPPER_W-1:0] w_upper;
    logic               w_alt;
    logic               w_is_i;
    logic               w_is_r;
    logic               w_is_shift;
    logic               w_legal;
    logic [SHAMT_W-1:0] w_shamt;
    shift_kind_e        w_kind;
    logic               w_multi;
    logic [XLEN-1:0]    w_alu;
    logic               w_out_free;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_start;
    logic               w_sh_busy;
    logic               w_sh_done;
    logic [XLEN-1:0]    w_sh_data;
    logic [XLEN-1:0]    w_sh_next;
    logic               w_unused;

    assign w_opcode   = inst_i[6:0];
    assign w_f3       = inst_i[14:12];
    assign w_f7       = inst_i[31:25];
    assign w_rd       = inst_i[11:7];
    assign w_upper    = inst_i[31:20+SHAMT_W];
    assign w_alt      = inst_i[30];
    assign w_is_i     = (w_opcode == INST_TYPE_I);
    assign w_is_r     = (ENABLE_R != 0) && (w_opcode == INST_TYPE_R);
    assign w_is_shift = (w_f3 == F3_SLL) || (w_f3 == F3_SR);
    assign w_shamt    = op2_i[SHAMT_W-1:0];
    assign w_unused   = ^{inst_i[19:15], w_sh_busy};

    always_comb begin
        w_legal = 1'b0;
        if (w_is_i) begin
            if (w_f3 == F3_SLL) begin
                w_legal = (w_upper == '0);
            end else if (w_f3 == F3_SR) begin
                w_legal = (w_upper == '0) || (w_upper == SRAI_UPPER);
            end else begin
                w_legal = 1'b1;
            end
        end else if (w_is_r) begin
            w_legal = (w_f7 == F7_BASE) ||
                      ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD) || (w_f3 == F3_SR)));
        end
    end

    // For legal instructions bit 30 alone separates SRA from SRL.
    assign w_kind  = (w_f3 == F3_SLL) ? SH_SLL : (w_alt ? SH_SRA : SH_SRL);
    assign w_multi = w_legal && w_is_shift && (w_shamt != '0);

    always_comb begin
        w_alu = ZERO[XLEN-1:0];
        if (w_legal) begin
            case (w_f3)
                F3_ADD:  w_alu = (w_is_r && w_alt) ? (op1_i - op2_i) : (op1_i + op2_i);
                F3_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
                F3_SLTU: w_alu = {{(XLEN-1){1'b0}}, (op1_i < op2_i)};
                F3_XOR:  w_alu = op1_i ^ op2_i;
                F3_OR:   w_alu = op1_i | op2_i;
                F3_AND:  w_alu = op1_i & op2_i;
                default: w_alu = op1_i;    // shift by zero
            endcase
        end
    end

    assign w_out_free = !r_valid || out_ready_i;
    assign w_in_ready = !rst_i && (r_state == ST_IDLE) && w_out_free;
    assign w_accept   = in_valid_i && w_in_ready;
    assign w_start    = w_accept && w_multi;

    exe_shift_serial #(
        .XLEN       (XLEN),
        .SHAMT_W    (SHAMT_W),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (w_start),
        .kind_i  (w_kind),
        .data_i  (op1_i),
        .amt_i   (w_shamt),
        .busy_o  (w_sh_busy),
        .done_o  (w_sh_done),
        .data_o  (w_sh_data),
        .next_o  (w_sh_next)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_sh_done) begin
                        r_state <= w_out_free ? ST_IDLE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_out_free) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid   <= 1'b0;
            r_wdata   <= '0;
            r_we      <= WRITE_DISABLE;
            r_rd      <= '0;
            r_rd_pend <= '0;
        end else begin
            if (w_accept) begin
                r_rd_pend <= w_rd;
            end
            if (w_accept && !w_multi) begin
                r_valid <= 1'b1;
                r_wdata <= w_alu;
                r_we    <= w_legal ? WRITE_ENABLE : WRITE_DISABLE;
                r_rd    <= w_rd;
            end else if ((r_state == ST_SHIFT) && w_sh_done && w_out_free) begin
                // Final step bypasses the shift register straight into the result.
                r_valid <= 1'b1;
                r_wdata <= w_sh_next;
                r_we    <= WRITE_ENABLE;
                r_rd    <= r_rd_pend;
            end else if ((r_state == ST_HOLD) && w_out_free) begin
                r_valid <= 1'b1;
                r_wdata <= w_sh_data;
                r_we    <= WRITE_ENABLE;
                r_rd    <= r_rd_pend;
            end else if (out_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_valid;
    assign reg_wdata_o = r_wdata;
    assign reg_we_o    = r_we;
    assign rd_o        = r_rd;
    assign busy_o      = (r_state != ST_IDLE);

endmodule
